// File: rtl/led_sequencer.sv
// led_sequencer: LED pattern sequencer (walk / bounce / fill / blink) with a
// programmable step prescaler, direction mirroring and run/hold control.
// Ports: clk, rst_n (async active-low), enable, mode[1:0], dir, speed[1:0],
//        led[NUM_LEDS-1:0] (registered), step_pulse, wrap (one-cycle strobes).
// Optional: define LED_PWM_EN to add bright[3:0] and a 16-step PWM dimmer on led.
module led_sequencer #(
  parameter int NUM_LEDS    = 8,
  parameter int STEP_CYCLES = 12000000,
  parameter int CNT_W       = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic                dir,
  input  logic [1:0]          speed,
`ifdef LED_PWM_EN
  input  logic [3:0]          bright,
`endif
  output logic [NUM_LEDS-1:0] led,
  output logic                step_pulse,
  output logic                wrap
);

  localparam int POS_W = $clog2(NUM_LEDS);
  localparam int LVL_W = $clog2(NUM_LEDS + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] POS_PEN  = POS_W'(NUM_LEDS - 2);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(NUM_LEDS);
  localparam logic [CNT_W-1:0] STEP_LIM = CNT_W'(STEP_CYCLES);

  typedef enum logic [1:0] {
    MODE_WALK   = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_FILL   = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  mode_e             mode_q, mode_in;
  logic [CNT_W-1:0]  cnt_q, cnt_d, limit;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              bdir_q, bdir_d;
  logic              phase_q, phase_d;
  logic              tick, wrap_d;
  logic [NUM_LEDS-1:0] pat, pat_mir, led_d;
`ifdef LED_PWM_EN
  logic [3:0]        pwm_q;
`endif

  assign mode_in = mode_e'(mode);

  always_comb begin
    limit   = STEP_LIM >> speed;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    lvl_d   = lvl_q;
    bdir_d  = bdir_q;
    phase_d = phase_q;
    tick    = 1'b0;
    wrap_d  = 1'b0;

    if (mode_in != mode_q) begin
      // Mode switch restarts the new pattern from its start, silently.
      cnt_d   = '0;
      pos_d   = '0;
      lvl_d   = '0;
      bdir_d  = 1'b0;
      phase_d = 1'b0;
    end else if (enable) begin
      // >= rather than == so shortening the period mid-step ticks at once.
      if (cnt_q >= limit - CNT_W'(1)) begin
        tick  = 1'b1;
        cnt_d = '0;
        case (mode_q)
          MODE_WALK: begin
            if (pos_q == POS_LAST) begin
              pos_d  = '0;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end
          MODE_BOUNCE: begin
            if (!bdir_q) begin
              pos_d = pos_q + POS_W'(1);
              if (pos_q == POS_PEN) bdir_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_W'(1);
              if (pos_q == POS_ONE) begin
                bdir_d = 1'b0;
                wrap_d = 1'b1;
              end
            end
          end
          MODE_FILL: begin
            if (lvl_q == LVL_LAST) begin
              lvl_d  = '0;
              wrap_d = 1'b1;
            end else begin
              lvl_d = lvl_q + LVL_W'(1);
            end
          end
          default: begin
            phase_d = ~phase_q;
            wrap_d  = phase_q;
          end
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Decode from next-state values so led moves on the same edge as the state.
    pat = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode_in)
        MODE_WALK, MODE_BOUNCE: pat[i] = (pos_d == POS_W'(i));
        MODE_FILL:              pat[i] = (LVL_W'(i) < lvl_d);
        default:                pat[i] = ~phase_d;
      endcase
    end

    for (int i = 0; i < NUM_LEDS; i++) begin
      pat_mir[i] = dir ? pat[NUM_LEDS-1-i] : pat[i];
    end

`ifdef LED_PWM_EN
    led_d = pat_mir & {NUM_LEDS{pwm_q < bright}};
`else
    led_d = pat_mir;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_WALK;
      cnt_q      <= '0;
      pos_q      <= '0;
      lvl_q      <= '0;
      bdir_q     <= 1'b0;
      phase_q    <= 1'b0;
      led        <= '0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
`ifdef LED_PWM_EN
      pwm_q      <= 4'd0;
`endif
    end else begin
      mode_q     <= mode_in;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      lvl_q      <= lvl_d;
      bdir_q     <= bdir_d;
      phase_q    <= phase_d;
      led        <= led_d;
      step_pulse <= tick;
      wrap       <= wrap_d;
`ifdef LED_PWM_EN
      pwm_q      <= pwm_q + 4'd1;
`endif
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: drives led_sequencer with directed and random stimulus and
// compares led/step_pulse/wrap each cycle against a sequence-table model.
module tb_led_sequencer;
  localparam int N  = 8;
  localparam int SC = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b1;
  logic         dir = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [1:0]   speed = 2'b00;
  logic [N-1:0] led;
  logic         step_pulse, wrap;
`ifdef LED_PWM_EN
  logic [3:0]   bright = 4'd15;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model: each mode is a fixed list of LED images; a step advances an index.
  int         m_mode, m_cnt, m_idx, m_pwm;
  logic [7:0] exp_led;
  logic       exp_sp, exp_wr;
  int         wrap_seen, step_seen;

  led_sequencer #(.NUM_LEDS(N), .STEP_CYCLES(SC), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .dir(dir),
    .speed(speed),
`ifdef LED_PWM_EN
    .bright(bright),
`endif
    .led(led), .step_pulse(step_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int seq_len(input int md);
    case (md)
      0: return N;
      1: return 2 * (N - 1);
      2: return N + 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] seq_val(input int md, input int idx);
    int v;
    case (md)
      0: v = 1 << idx;
      1: v = 1 << ((idx < N) ? idx : (2 * (N - 1) - idx));
      2: v = (1 << idx) - 1;
      default: v = (idx == 0) ? 255 : 0;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [7:0] mirror8(input logic [7:0] v, input logic d);
    logic [7:0] r;
    for (int i = 0; i < N; i++) r[i] = d ? v[N-1-i] : v[i];
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_idx = 0; m_pwm = 0;
  endtask

  task automatic model_step();
    int lim;
    exp_sp = 1'b0;
    exp_wr = 1'b0;
    lim = SC >> speed;
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_cnt = 0; m_idx = 0;
    end else if (enable) begin
      if (m_cnt >= lim - 1) begin
        m_cnt  = 0;
        m_idx  = (m_idx + 1) % seq_len(m_mode);
        exp_sp = 1'b1;
        exp_wr = (m_idx == 0);
      end else begin
        m_cnt++;
      end
    end
    exp_led = mirror8(seq_val(m_mode, m_idx), dir);
`ifdef LED_PWM_EN
    if (!(m_pwm < int'(bright))) exp_led = 8'h00;
    m_pwm = (m_pwm + 1) % 16;
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("led", 32'(led), 32'(exp_led));
    check("step_pulse", 32'(step_pulse), 32'(exp_sp));
    check("wrap", 32'(wrap), 32'(exp_wr));
    if (wrap === 1'b1) wrap_seen++;
    if (step_pulse === 1'b1) step_seen++;
  endtask

  // Pulse reset between clock edges; outputs must clear without waiting for clk.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_step", 32'(step_pulse), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] held;
    bit found;

    model_reset();
    #12;
    check("reset_led", 32'(led), 32'h0);
    check("reset_step", 32'(step_pulse), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Walk: one full lap plus one step; exactly one wrap (0x80 -> 0x01).
    wrap_seen = 0;
    cycle();
    check("first_led", 32'(led), 32'h01);
    repeat (71) cycle();
    check("walk_wraps", 32'(wrap_seen), 32'd1);

    // Advance to led=0x08 with the prescaler at 5, then speed up to /8.
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_idx == 3 && m_cnt == 5) found = 1;
      else cycle();
    end
    check("sync_speed", 32'(found), 32'd1);
    speed = 2'd3;
    cycle();
    check("fast_step", 32'(step_pulse), 32'd1);
    repeat (3) cycle();

    // Hold: nothing moves for 20 cycles while disabled.
    enable = 1'b0;
    cycle();
    held = led;
    step_seen = 0;
    repeat (20) cycle();
    check("hold_led", 32'(led), 32'(held));
    check("hold_strobes", 32'(step_seen), 32'd0);
    enable = 1'b1;
    speed = 2'd0;
    repeat (10) cycle();

    // Walk -> blink switch at led=0x10.
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_mode == 0 && m_idx == 4) found = 1;
      else cycle();
    end
    check("sync_blink", 32'(found), 32'd1);
    mode = 2'b11;
    cycle();
    check("blink_start", 32'(led), 32'hFF);
    repeat (40) cycle();

    // Bounce: one full period, then reset mid-sequence and restart.
    mode = 2'b01;
    wrap_seen = 0;
    repeat (1 + 14 * 8) cycle();
    check("bounce_wraps", 32'(wrap_seen), 32'd1);
    repeat (27) cycle();
    async_reset();
    cycle();
    check("bounce_restart", 32'(led), 32'h01);
    repeat (20) cycle();

    // Fill, mirrored: 9 steps per period.
    mode = 2'b10;
    dir = 1'b1;
    wrap_seen = 0;
    repeat (1 + 9 * 8) cycle();
    check("fill_wraps", 32'(wrap_seen), 32'd1);

    // Random phase.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(199) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(49) == 0) speed = 2'($urandom_range(3));
      if ($urandom_range(99) == 0) dir = ~dir;
      enable = ($urandom_range(9) != 0);
`ifdef LED_PWM_EN
      if ($urandom_range(99) == 0) bright = 4'($urandom_range(15));
`endif
      if ($urandom_range(999) == 0) async_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised LED pattern sequencer driving NUM_LEDS board LEDs from the fabric clock.
- Runtime-selectable patterns: walk, bounce, fill, blink.
- Runtime-selectable direction and step rate, plus run/hold control.
- Emits step and sequence-wrap strobes so other blocks can sync to the display.

Parameters:
- NUM_LEDS, 8, number of LED outputs; legal range 2..32.
- STEP_CYCLES, 12000000, clocks per step at speed=0; 1 s at 12 MHz; minimum 8.
- CNT_W, 24, prescaler width; must satisfy 2^CNT_W > STEP_CYCLES.

Ports:
- clk  in  1  fabric clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = run; 0 = hold prescaler and pattern state.
- mode  in  2  00 walk, 01 bounce, 10 fill, 11 blink.
- dir  in  1  0 = index 0 toward NUM_LEDS-1; 1 = mirrored.
- speed  in  2  step period = STEP_CYCLES >> speed, i.e. /1, /2, /4, /8.
- led  out  NUM_LEDS  registered LED drive, active-high.
- step_pulse  out  1  one-cycle strobe on each applied step.
- wrap  out  1  one-cycle strobe when the sequence returns to its start.

Behaviour:
- Reset values: cnt=0, pos=0, lvl=0, bdir=0, phase=0, mode_q=00. Outputs led=0, step_pulse=0, wrap=0.
- Prescaler:
  - limit = STEP_CYCLES >> speed.
  - tick when enable && cnt >= limit-1, then cnt<=0. Otherwise, if enable, cnt<=cnt+1.
  - The >= compare makes a speed increase mid-period tick on the next cycle; it never waits for a counter wrap.
- Mode change (mode != mode_q), independent of enable:
  - Next edge: mode_q<=mode, cnt<=0, pos<=0, lvl<=0, bdir<=0, phase<=0.
  - No tick, step_pulse or wrap on that edge.
- On tick:
  - WALK: pos<=pos+1; at NUM_LEDS-1, pos<=0 and wrap=1.
  - BOUNCE:
    - bdir=0: pos+1; on reaching NUM_LEDS-1, bdir<=1.
    - bdir=1: pos-1; on reaching 0, bdir<=0 and wrap=1.
    - Endpoints are each shown for exactly one step; period = 2*(NUM_LEDS-1) steps.
  - FILL: lvl cycles 0..NUM_LEDS (NUM_LEDS+1 steps); NUM_LEDS->0 asserts wrap.
  - BLINK: phase toggles; wrap on the 1->0 transition.
- Strobes: step_pulse=1 on every tick edge. wrap coincides with step_pulse.
- LED decode, pre-mirror, from the next-state values:
  - WALK/BOUNCE: one-hot bit pos.
  - FILL: low lvl bits set.
  - BLINK: all ones when phase=0, else 0.
- Mirror: dir=1 maps bit i to NUM_LEDS-1-i.
- led is registered from the decode every cycle. Consequences:
  - led changes on the same edge as the state.
  - A dir change mirrors on the next edge without restarting.
  - No combinational path from inputs to led.
- enable=0: cnt and pattern state are held; led keeps the current pattern; no strobes.
- Reset asserted mid-sequence: all registers clear immediately, asynchronously.
- Reset release: first edge loads led with the start pattern of the current mode.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - Adds input bright [3:0] and a free-running 4-bit PWM counter, reset 0.
  - Every led bit is ANDed with (pwm_cnt < bright), registered.
  - bright=0 gives all LEDs off; bright=15 gives 15/16 duty.
  - Pattern, strobes and timing are unchanged.
- Undefined: bright port absent; led is the undimmed pattern.

Test Plan:
- Test parameters for all cases: NUM_LEDS=8, STEP_CYCLES=8.
- Reset, mode=00, dir=0, speed=0, enable=1 -> led=0x01 after first edge. Then a step every 8 clocks: 0x02, 0x04 … 0x80, 0x01. wrap pulses with the 0x80->0x01 step only.
- mode=01 -> sequence 0x01,0x02…0x80,0x40…0x01, 14 steps per wrap. 0x80 and 0x01 each held for one step.
- mode=10, dir=1 -> 0x00,0x80,0xC0…0xFF,0x00. wrap on 0xFF->0x00; 9 steps per period.
- Mid-walk at led=0x08:
  - set speed=3 with cnt=5 -> step on next cycle, then every 1 clock.
  - set enable=0 -> led holds 0x08 and no strobes for 20 clocks.
  - re-enable -> resumes.
- Mode change 00->11 at led=0x10 -> next edge led=0xFF, cnt=0, no strobe. Then toggles 0x00/0xFF every 8 clocks.
- rst_n pulsed low mid-bounce, asynchronously between edges -> led=0 at once. After release, led restarts at 0x01 with bdir=0.
- With LED_PWM_EN: bright=4, walk at 0x01 -> led[0] high for 4 of every 16 clocks. bright=0 -> led constant 0.
